// File: rtl/program_loader.sv
// program_loader: boot-time loader that streams a big-endian image
// (16-bit word count, then 4 bytes per word, MSB first) into program memory
// and holds the processor in reset until the whole image has been written.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int          MEMORY_DEPTH = 64,
  parameter logic [31:0] BASE_ADDR    = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  byte_data_i,
  input  logic        byte_valid_i,
  output logic        byte_ready_o,
  output logic        mem_write_o,
  output logic [31:0] mem_address_o,
  output logic [31:0] mem_data_o,
  output logic [15:0] word_count_o,
  output logic        cpu_reset_o,
  output logic        done_o,
  output logic        error_o
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_WORD, S_WRITE, S_DONE, S_ERROR, S_CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_WORD, S_WRITE, S_DONE, S_ERROR
  } state_t;
`endif

  localparam logic [15:0] DEPTH16 = 16'(MEMORY_DEPTH);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  len_hi_q;
  logic [15:0] len_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] word_q;
  logic [15:0] len_in;
  logic        last_word;
  logic        xfer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  // Full length as seen on the LEN_LO transfer edge, and last-word detect.
  assign len_in    = {len_hi_q, byte_data_i};
  assign last_word = (word_count_o == (len_q - 16'd1));
  assign xfer      = byte_valid_i & byte_ready_o;

  // State register; reset drops straight back to IDLE, aborting any load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and state-derived outputs (all outputs depend on state only).
  always_comb begin
    state_d      = state_q;
    byte_ready_o = 1'b0;
    mem_write_o  = 1'b0;
    cpu_reset_o  = 1'b0;
    done_o       = 1'b0;
    error_o      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) begin
          if ((len_in == 16'd0) || (len_in > DEPTH16)) state_d = S_ERROR;
          else                                         state_d = S_WORD;
        end
      end
      S_WORD: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i && (byte_cnt_q == 2'd3)) state_d = S_WRITE;
      end
      S_WRITE: begin
        mem_write_o = 1'b1;
        if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end else begin
          state_d = S_WORD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready_o = 1'b1;
        if (byte_valid_i) state_d = (byte_data_i == csum_q) ? S_DONE : S_ERROR;
      end
`endif
      S_DONE: begin
        cpu_reset_o = 1'b1;
        done_o      = 1'b1;
        if (start_i) state_d = S_LEN_HI;
      end
      S_ERROR: begin
        error_o = 1'b1;
        if (start_i) state_d = S_LEN_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: length latch, word assembly, write address/data capture, counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_hi_q      <= 8'd0;
      len_q         <= 16'd0;
      byte_cnt_q    <= 2'd0;
      word_q        <= 32'd0;
      mem_address_o <= 32'd0;
      mem_data_o    <= 32'd0;
      word_count_o  <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
      csum_q        <= 8'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_i) begin
            word_count_o <= 16'd0;
            byte_cnt_q   <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= 8'd0;
`endif
          end
        end
        S_LEN_HI: begin
          if (xfer) len_hi_q <= byte_data_i;
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_q      <= len_in;
            byte_cnt_q <= 2'd0;
          end
        end
        S_WORD: begin
          if (xfer) begin
            word_q     <= {word_q[23:0], byte_data_i};
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_q ^ byte_data_i;
`endif
            // Capture the completed word and its address so both stay put
            // through WRITE and afterwards until the next write.
            if (byte_cnt_q == 2'd3) begin
              mem_data_o    <= {word_q[23:0], byte_data_i};
              mem_address_o <= BASE_ADDR + {14'd0, word_count_o, 2'b00};
            end
          end
        end
        S_WRITE: begin
          word_count_o <= word_count_o + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time instruction loader that sits directly upstream of the MIPS processor's program memory.
- Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit instruction words, and writes them sequentially into program memory.
- Holds the processor in reset until the full image is loaded, then releases it.
- Malformed images are rejected and the processor stays in reset.

Parameters:
- MEMORY_DEPTH, 64, program memory capacity in words; maximum legal image length.
- BASE_ADDR, 32'h0040_0000, byte address of word 0 in program memory (text-segment base).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start_i  input  1  load request; honoured in IDLE, DONE and ERROR.
- byte_data_i  input  8  incoming image byte.
- byte_valid_i  input  1  byte_data_i holds a valid byte.
- byte_ready_o  output  1  loader accepts a byte this cycle.
- mem_write_o  output  1  one-cycle program-memory write strobe.
- mem_address_o  output  32  byte address of the word being written.
- mem_data_o  output  32  instruction word being written.
- word_count_o  output  16  number of words written so far in the current load.
- cpu_reset_o  output  1  active-low reset to the processor; 1 only in DONE.
- done_o  output  1  image loaded successfully.
- error_o  output  1  image rejected.

Behaviour:
- Reset is asynchronous: on reset=0, state=IDLE and all outputs are 0, including cpu_reset_o, which holds the processor in reset. Internal length, index and byte counters are cleared. Reset asserted mid-load aborts the load immediately; writes already issued are not undone.
- Handshake: a byte transfers on a rising edge where byte_valid_i & byte_ready_o. byte_ready_o=1 only in LEN_HI, LEN_LO and WORD (and CHK when the optional feature is enabled). Upstream holds byte_data_i stable while valid and not ready.
- Image format: 16-bit big-endian word count N, followed by 4N bytes, each word most-significant byte first.
- State machine:
  - IDLE: start_i=1 -> LEN_HI; clear word_count_o and index.
  - LEN_HI: on transfer, latch N[15:8] -> LEN_LO.
  - LEN_LO: on transfer, latch N[7:0]. The length check uses the full 16-bit value {latched high byte, incoming byte}. N==0 or N>MEMORY_DEPTH -> ERROR; otherwise -> WORD with byte counter 0.
  - WORD: each transfer shifts the byte into the word register (shift left by 8, byte enters bits [7:0]). The 4th transfer, when byte counter wraps 3->0, -> WRITE.
  - WRITE: exactly one cycle.
    - mem_write_o=1, mem_address_o=BASE_ADDR+4*index, mem_data_o=assembled word.
    - At the end of the cycle, index and word_count_o increment.
    - If index==N-1 -> DONE (or CHK when enabled); else -> WORD.
  - DONE: cpu_reset_o=1, done_o=1. start_i=1 -> LEN_HI; cpu_reset_o and done_o return to 0 on the same edge.
  - ERROR: error_o=1, cpu_reset_o=0. start_i=1 -> LEN_HI; error_o is cleared on that edge.
- Output timing:
  - mem_write_o is 0 in every state except WRITE.
  - mem_address_o and mem_data_o are valid only while mem_write_o=1 and hold their last value otherwise.
- Throughput and latency:
  - Best-case throughput is 1 word per 5 cycles (4 byte transfers + 1 write cycle).
  - Latency from the last image byte to cpu_reset_o=1 is 2 edges: one into WRITE, one into DONE.
- Boundaries:
  - N==MEMORY_DEPTH is legal; the last address is BASE_ADDR+4*(MEMORY_DEPTH-1).
  - start_i in LEN_HI, LEN_LO, WORD, WRITE or CHK is ignored.
  - byte_valid_i while not ready is ignored; no byte is consumed.
  - Address arithmetic is 32-bit unsigned, with no wrap within a legal N.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE the FSM enters CHK, with byte_ready_o=1, and accepts one checksum byte.
  - The checksum is the XOR of all 4N data bytes; length bytes are excluded.
  - On a match -> DONE; on a mismatch -> ERROR.
  - Words already written remain in memory, but the processor stays in reset.
- Undefined: CHK does not exist, and the last WRITE goes directly to DONE.

Test Plan:
- Reset, then start_i, then bytes 00 02 20 08 00 05 21 29 00 03 -> mem_write_o pulses twice: addr 0x00400000 data 0x20080005, then addr 0x00400004 data 0x21290003. word_count_o=2; done_o=1 and cpu_reset_o=1 two edges after the last byte.
- Length bytes 00 00 -> ERROR, error_o=1, cpu_reset_o=0, no mem_write_o pulse. Length 00 41 with MEMORY_DEPTH=64 -> ERROR.
- Length 00 40 (64) followed by 256 bytes -> 64 writes, last at addr 0x004000FC; done_o=1.
- byte_valid_i toggled randomly 50% during a 3-word load -> identical memory writes to the continuous-stream case; no byte lost or duplicated while byte_ready_o=0 in WRITE.
- reset driven low after 6 bytes of a 2-word load -> all outputs 0 immediately without waiting for a clock edge. A new start_i and full image then load correctly from word 0.
- LOADER_CHECKSUM_EN defined, image 00 01 AA BB CC DD with checksum 00 -> DONE; same image with checksum 01 -> ERROR, cpu_reset_o=0.
